// File: rtl/micro_sequencer.sv
// Next-micro-address controller for the multicycle microprogrammed MIPS datapath.
// Selects the next uPC each cycle, stalls on memory waits, recovers from unmapped opcodes and counts retirements.
module micro_sequencer #(
    parameter logic [4:0] FETCH_ADDR = 5'd0,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       addr_ctl,
    input  logic             mem_op,
    input  logic             mem_ready,
    input  logic [5:0]       opcode,
    output logic [4:0]       upc,
    output logic [1:0]       sel,
    output logic             stall,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SEL_SEQ   = 2'b00;
    localparam logic [1:0] SEL_DISP1 = 2'b01;
    localparam logic [1:0] SEL_DISP2 = 2'b10;
    localparam logic [1:0] SEL_FETCH = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0] d1_addr;
    logic       d1_hit;
    logic [4:0] d2_addr;
    logic [4:0] upc_nxt;

    always_comb begin
        d1_addr = FETCH_ADDR;
        d1_hit  = 1'b1;
        case (opcode)
            OP_RTYPE: d1_addr = 5'd6;
            OP_LW:    d1_addr = 5'd2;
            OP_SW:    d1_addr = 5'd2;
            OP_BEQ:   d1_addr = 5'd8;
            OP_J:     d1_addr = 5'd9;
            OP_ADDI:  d1_addr = 5'd10;
            default:  d1_hit  = 1'b0;
        endcase
    end

    always_comb begin
        d2_addr = FETCH_ADDR;
        case (opcode)
            OP_LW:   d2_addr = 5'd3;
            OP_SW:   d2_addr = 5'd5;
            default: d2_addr = FETCH_ADDR;
        endcase
    end

    // A memory wait outranks an unmapped dispatch, so illegal_op is masked during a stall.
    assign stall      = mem_op & ~mem_ready;
    assign illegal_op = ~stall & (addr_ctl == SEL_DISP1) & ~d1_hit;
    assign sel        = illegal_op ? SEL_FETCH : addr_ctl;

    always_comb begin
        upc_nxt = FETCH_ADDR;
        case (sel)
            SEL_SEQ:   upc_nxt = upc + 5'd1;
            SEL_DISP1: upc_nxt = d1_addr;
            SEL_DISP2: upc_nxt = d2_addr;
            default:   upc_nxt = FETCH_ADDR;
        endcase
    end

    // Only an explicit fetch retires; illegal-opcode recovery also lands on FETCH_ADDR but is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc     <= FETCH_ADDR;
            retired <= '0;
        end else if (!stall) begin
            upc <= upc_nxt;
            if (addr_ctl == SEL_FETCH)
                retired <= retired + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed vector table, hand-written corner sequences,
// and randomized stimulus against a behavioural next-address model.
module tb_micro_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    addr_ctl;
    logic          mem_op;
    logic          mem_ready;
    logic [5:0]    opcode;
    logic [4:0]    upc;
    logic [1:0]    sel;
    logic          stall;
    logic          illegal_op;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;

    micro_sequencer #(.FETCH_ADDR(5'd0), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .addr_ctl(addr_ctl), .mem_op(mem_op),
        .mem_ready(mem_ready), .opcode(opcode), .upc(upc), .sel(sel),
        .stall(stall), .illegal_op(illegal_op), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ac;
        logic       mo;
        logic       mr;
        logic [5:0] op;
        logic [1:0] e_sel;
        logic       e_stall;
        logic       e_ill;
        int         e_upc;
        int         e_ret;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] ac, input logic mo, input logic mr, input logic [5:0] op);
        addr_ctl  = ac;
        mem_op    = mo;
        mem_ready = mr;
        opcode    = op;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] ac, input logic mo, input logic mr, input logic [5:0] op,
                                input logic [1:0] es, input logic est, input logic eil, input int eu, input int er);
        vec_t v;
        v.ac = ac; v.mo = mo; v.mr = mr; v.op = op;
        v.e_sel = es; v.e_stall = est; v.e_ill = eil; v.e_upc = eu; v.e_ret = er;
        return v;
    endfunction

    // Reference dispatch tables; -1 marks an unmapped opcode.
    function automatic int disp1(input int op);
        case (op)
            'h00: return 6;
            'h23: return 2;
            'h2B: return 2;
            'h04: return 8;
            'h02: return 9;
            'h08: return 10;
            default: return -1;
        endcase
    endfunction

    function automatic int disp2(input int op);
        if (op == 'h23) return 3;
        if (op == 'h2B) return 5;
        return 0;
    endfunction

    initial begin
        int m_upc;
        int m_ret;
        int e_sel;
        int e_ill;
        int e_st;
        int d;
        logic [5:0] op_pool [8];

        vecs.push_back(mk(2'b00, 0, 1, 6'h23, 2'b00, 0, 0, 1, 0));
        vecs.push_back(mk(2'b01, 0, 0, 6'h23, 2'b01, 0, 0, 2, 0));
        vecs.push_back(mk(2'b10, 0, 0, 6'h23, 2'b10, 0, 0, 3, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(2'b00, 1, 0, 6'h23, 2'b00, 1, 0, 3, 0));
        vecs.push_back(mk(2'b00, 1, 1, 6'h23, 2'b00, 0, 0, 4, 0));
        vecs.push_back(mk(2'b11, 0, 0, 6'h23, 2'b11, 0, 0, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 6'h3F, 2'b00, 0, 0, 1, 1));
        vecs.push_back(mk(2'b01, 0, 0, 6'h3F, 2'b11, 0, 1, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 6'h3F, 2'b00, 0, 0, 1, 1));
        vecs.push_back(mk(2'b01, 1, 0, 6'h3F, 2'b00, 1, 0, 1, 1));
        vecs.push_back(mk(2'b01, 1, 1, 6'h00, 2'b01, 0, 0, 6, 1));
        vecs.push_back(mk(2'b11, 1, 0, 6'h00, 2'b00, 1, 0, 6, 1));
        vecs.push_back(mk(2'b11, 0, 1, 6'h00, 2'b11, 0, 0, 0, 2));
        vecs.push_back(mk(2'b00, 0, 0, 6'h2B, 2'b00, 0, 0, 1, 2));
        vecs.push_back(mk(2'b01, 0, 0, 6'h2B, 2'b01, 0, 0, 2, 2));
        vecs.push_back(mk(2'b10, 0, 0, 6'h2B, 2'b10, 0, 0, 5, 2));
        vecs.push_back(mk(2'b11, 0, 0, 6'h2B, 2'b11, 0, 0, 0, 3));
        vecs.push_back(mk(2'b00, 0, 0, 6'h04, 2'b00, 0, 0, 1, 3));
        vecs.push_back(mk(2'b01, 0, 0, 6'h04, 2'b01, 0, 0, 8, 3));
        vecs.push_back(mk(2'b00, 0, 0, 6'h04, 2'b00, 0, 0, 9, 3));
        vecs.push_back(mk(2'b10, 0, 0, 6'h04, 2'b10, 0, 0, 0, 3));

        // Reset and sequential walk through all 32 addresses.
        rst_n = 1'b0;
        drive(2'b00, 0, 0, 6'h00);
        chk("reset_upc", upc, 0);
        chk("reset_retired", retired, 0);
        chk("reset_sel", sel, 0);
        tick;
        tick;
        chk("reset_hold_upc", upc, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(2'b00, 0, 0, 6'h00);
            chk("seq_sel", sel, 0);
            chk("seq_stall", stall, 0);
            tick;
            chk("seq_upc", upc, (i + 1) % 32);
        end
        chk("seq_retired", retired, 0);

        // Directed vector table: lw path, stall, illegal opcode, sw/beq paths.
        foreach (vecs[i]) begin
            drive(vecs[i].ac, vecs[i].mo, vecs[i].mr, vecs[i].op);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_illegal", i), illegal_op, vecs[i].e_ill);
            if (!vecs[i].e_stall)
                chk($sformatf("vec%0d_sel", i), sel, vecs[i].e_sel);
            tick;
            chk($sformatf("vec%0d_upc", i), upc, vecs[i].e_upc);
            chk($sformatf("vec%0d_retired", i), retired, vecs[i].e_ret);
        end

        // Asynchronous reset while stalled at uPC 3.
        drive(2'b00, 0, 0, 6'h23); tick;
        drive(2'b01, 0, 0, 6'h23); tick;
        drive(2'b10, 0, 0, 6'h23); tick;
        drive(2'b00, 1, 0, 6'h23); tick;
        chk("midstall_upc", upc, 3);
        chk("midstall_stall", stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_upc", upc, 0);
        chk("async_rst_retired", retired, 0);
        #1;
        rst_n = 1'b1;
        drive(2'b00, 0, 0, 6'h00);
        tick;
        chk("post_rst_upc", upc, 1);
        drive(2'b11, 0, 0, 6'h00);
        tick;
        chk("post_rst_fetch_upc", upc, 0);
        chk("post_rst_retired", retired, 1);

        // Counter wrap: reset, then 17 R-type instructions on a 4-bit counter.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            drive(2'b00, 0, 0, 6'h00); tick;
            drive(2'b01, 0, 0, 6'h00); tick;
            chk("rtype_disp_upc", upc, 6);
            drive(2'b00, 0, 0, 6'h00); tick;
            drive(2'b11, 0, 0, 6'h00); tick;
            chk("wrap_upc", upc, 0);
            chk("wrap_retired", retired, k % 16);
        end

        // Randomized stimulus against the behavioural model.
        op_pool = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
        m_upc = upc;
        m_ret = retired;
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] ac;
            logic       mo, mr;
            logic [5:0] op;
            ac = 2'($urandom_range(0, 3));
            mo = ($urandom_range(0, 3) == 0);
            mr = ($urandom_range(0, 2) != 0);
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 7)];
            drive(ac, mo, mr, op);

            e_st  = (mo && !mr) ? 1 : 0;
            d     = disp1(op);
            e_ill = (!e_st && ac == 1 && d < 0) ? 1 : 0;
            e_sel = e_ill ? 3 : ac;
            chk("rnd_stall", stall, e_st);
            chk("rnd_illegal", illegal_op, e_ill);
            if (!e_st) begin
                chk("rnd_sel", sel, e_sel);
                case (e_sel)
                    0: m_upc = (m_upc + 1) % 32;
                    1: m_upc = d;
                    2: m_upc = disp2(op);
                    default: m_upc = 0;
                endcase
                if (ac == 3) m_ret = (m_ret + 1) % (1 << CW);
            end
            tick;
            chk("rnd_upc", upc, m_upc);
            chk("rnd_retired", retired, m_ret);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
